// File: rtl/variable_rshift_pipe_pkg.sv
// Shared definitions for the pipelined right shifter: fill-mode encoding,
// default width and the log2 helper used to size the shift-amount port.
package variable_rshift_pipe_pkg;

  typedef enum logic {
    FILL_ZERO = 1'b0,
    FILL_SIGN = 1'b1
  } fill_mode_e;

  localparam int DEF_DATA_W = 16;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/variable_rshift_pipe_rshift_stage.sv
// One pipeline stage: registered conditional right shift (or rotate) by SHAMT, 1 cycle.
// Holds data and valid whenever i_en is low; async active-low reset clears both.
module variable_rshift_pipe_rshift_stage
  import variable_rshift_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SHAMT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_vld,
  input  logic              i_sel,
  input  logic              i_fill,
  input  logic              i_rot,
  input  logic [DATA_W-1:0] i_dat,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_dat
);

  logic [DATA_W-1:0] w_shifted;
  logic              r_vld;
  logic [DATA_W-1:0] r_dat;

  always_comb begin
    w_shifted = i_dat;
    if (i_sel) begin
      if (i_rot) w_shifted = {i_dat[SHAMT-1:0], i_dat[DATA_W-1:SHAMT]};
      else       w_shifted = {{SHAMT{i_fill}}, i_dat[DATA_W-1:SHAMT]};
    end
  end

  // Data moves even for bubbles; only the valid bit marks a real beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_en) begin
      r_vld <= i_vld;
      r_dat <= w_shifted;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/variable_rshift_pipe.sv
// Pipelined variable right shifter (log/arith), SHIFT_W-cycle latency, 1 beat/cycle.
// Whole pipe stalls while out_valid && !out_ready; in_ready mirrors that. ROTATE_EN adds in_rot.
module variable_rshift_pipe
  import variable_rshift_pipe_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  localparam int SHIFT_W = clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0] in_shamt,
  input  logic               in_arith,
`ifdef ROTATE_EN
  input  logic               in_rot,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data
);

  localparam int SB_W = SHIFT_W - 1;

  logic                         w_adv;
  logic [SHIFT_W:0]             w_vld;
  logic [SHIFT_W:0][DATA_W-1:0] w_dat;
  logic [SHIFT_W-1:0]           w_sel;
  logic [SHIFT_W-1:0]           w_fill;
  logic [SHIFT_W-1:0]           w_rot;
  fill_mode_e                   w_mode;
  logic [SB_W-1:0]              r_fill_pipe;
  logic [SB_W-1:0]              r_rot_pipe;

  assign w_adv     = !w_vld[SHIFT_W] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = w_vld[SHIFT_W];
  assign out_data  = w_dat[SHIFT_W];

  assign w_vld[0]  = in_valid;
  assign w_dat[0]  = in_data;
  assign w_sel[0]  = in_shamt[0];
  assign w_mode    = in_arith ? FILL_SIGN : FILL_ZERO;
  assign w_fill[0] = (w_mode == FILL_SIGN) ? in_data[DATA_W-1] : 1'b0;
`ifdef ROTATE_EN
  assign w_rot[0]  = in_rot;
`else
  assign w_rot[0]  = 1'b0;
`endif

  // Fill and rotate flags ride alongside the data, one register per stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_pipe <= '0;
      r_rot_pipe  <= '0;
    end else if (w_adv) begin
      r_fill_pipe <= SB_W'({r_fill_pipe, w_fill[0]});
      r_rot_pipe  <= SB_W'({r_rot_pipe, w_rot[0]});
    end
  end

  // Shamt bit k is delayed k cycles so it meets its data at stage k and then dies.
  for (genvar k = 1; k < SHIFT_W; k++) begin : g_side
    localparam int DLY_W = k;
    logic [DLY_W-1:0] r_amt_dly;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       r_amt_dly <= '0;
      else if (w_adv) r_amt_dly <= DLY_W'({r_amt_dly, in_shamt[k]});
    end

    assign w_sel[k]  = r_amt_dly[DLY_W-1];
    assign w_fill[k] = r_fill_pipe[k-1];
    assign w_rot[k]  = r_rot_pipe[k-1];
  end

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    variable_rshift_pipe_rshift_stage #(
      .DATA_W (DATA_W),
      .SHAMT  (1 << k)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_adv),
      .i_vld  (w_vld[k]),
      .i_sel  (w_sel[k]),
      .i_fill (w_fill[k]),
      .i_rot  (w_rot[k]),
      .i_dat  (w_dat[k]),
      .o_vld  (w_vld[k+1]),
      .o_dat  (w_dat[k+1])
    );
  end

endmodule

// File: tb/tb_variable_rshift_pipe.sv
// Bench for variable_rshift_pipe: directed vectors with literal results plus a
// random sweep, all checked against a plain-arithmetic shift/rotate model.
module tb_variable_rshift_pipe;

  localparam int W  = 16;
  localparam int SW = 4;
`ifdef ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data   = '0;
  logic [SW-1:0] in_shamt  = '0;
  logic          in_arith  = 1'b0;
  logic          in_rot    = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;

  always #5 clk = ~clk;

  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  variable_rshift_pipe #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
`ifdef ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic [W-1:0] exp;
    logic [W-1:0] lit;
    bit           has_lit;
    bit           lat_chk;
    int           acc;
  } beat_t;

  beat_t        q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc   = 0;
  bit           drv_has_lit = 1'b0;
  bit           drv_lat     = 1'b0;
  logic [W-1:0] drv_lit     = '0;
  bit           stall_prev  = 1'b0;
  logic [W-1:0] held        = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Right shift by s: rotate, arithmetic or logical, straight from the definition.
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input int s,
                                              input logic a, input logic r);
    logic [2*W-1:0]      dd;
    logic signed [W-1:0] sd;
    if (r) begin
      dd = {d, d} >> s;
      return dd[W-1:0];
    end
    sd = d;
    if (a) return sd >>> s;
    return d >> s;
  endfunction

  always @(negedge clk) begin : cmp
    beat_t b;
    cyc = cyc + 1;
    if (!rst) begin
      q.delete();
      stall_prev = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data",  32'(out_data),  32'(held));
      end
      if (out_valid) begin
        chk("valid_has_beat", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0 && out_ready) begin
          b = q.pop_front();
          chk("data_vs_model", 32'(out_data), 32'(b.exp));
          if (b.has_lit) begin
            chk("data_vs_literal", 32'(out_data), 32'(b.lit));
            chk("model_pin", 32'(b.exp), 32'(b.lit));
          end
          if (b.lat_chk) chk("latency", 32'(cyc - b.acc), 32'(SW));
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      if (in_valid && in_ready) begin
        b.exp     = ref_model(in_data, int'(in_shamt), in_arith, in_rot & ROT_ON);
        b.lit     = drv_lit;
        b.has_lit = drv_has_lit;
        b.lat_chk = drv_lat;
        b.acc     = cyc;
        q.push_back(b);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic a,
                      input logic r, input bit has, input logic [W-1:0] lit, input bit lat);
    bit took;
    in_valid    = 1'b1;
    in_data     = d;
    in_shamt    = s;
    in_arith    = a;
    in_rot      = r;
    drv_has_lit = has;
    drv_lit     = lit;
    drv_lat     = lat;
    took        = 1'b0;
    for (int i = 0; i < 200 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    chk("accept", 32'(took), 32'd1);
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    drv_has_lit = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  logic [W-1:0] t3 [4] = '{16'h0010, 16'h0008, 16'h0004, 16'h0002};
  logic [W-1:0] t4 [4] = '{16'hC000, 16'hE000, 16'hF000, 16'hF800};

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic logical shift with latency pinned
    send(16'hF000, 4'd4, 1'b0, 1'b0, 1'b1, 16'h0F00, 1'b1);
    drain();

    // Max amount, both fill modes, and boundary amounts
    send(16'h8001, 4'd15, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    send(16'h8001, 4'd15, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1);
    send(16'hA5C3, 4'd0,  1'b1, 1'b0, 1'b1, 16'hA5C3, 1'b1);
    send(16'hA5C3, 4'd0,  1'b0, 1'b0, 1'b1, 16'hA5C3, 1'b1);
    send(16'h7FFF, 4'd15, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
    send(16'h8421, 4'd7,  1'b1, 1'b0, 1'b1, 16'hFF08, 1'b1);
    send(16'h8421, 4'd7,  1'b0, 1'b0, 1'b1, 16'h0108, 1'b1);
    drain();

    // Back-to-back beats, one result per cycle
    for (int s = 0; s < 4; s++)
      send(16'h0010, 4'(s), 1'b0, 1'b0, 1'b1, t3[s], 1'b1);
    drain();

    // Full pipe, then downstream stall for three cycles
    for (int s = 0; s < 4; s++)
      send(16'hC000, 4'(s), 1'b1, 1'b0, 1'b1, t4[s], 1'b0);
    rdy_val = 1'b0;
    fork
      send(16'hBEEF, 4'd4, 1'b0, 1'b0, 1'b1, 16'h0BEE, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 rdy_val = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    send(16'h1111, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0888, 1'b1);
    send(16'h2222, 4'd2, 1'b0, 1'b0, 1'b1, 16'h0888, 1'b1);
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(16'h4000, 4'd2, 1'b0, 1'b0, 1'b1, 16'h1000, 1'b1);
    drain();

`ifdef ROTATE_EN
    send(16'h0001, 4'd1,  1'b0, 1'b1, 1'b1, 16'h8000, 1'b1);
    send(16'h1234, 4'd4,  1'b1, 1'b1, 1'b1, 16'h4123, 1'b1);
    send(16'h8001, 4'd15, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b1);
    drain();
`endif

    // Random sweep with random gaps and random downstream readiness
    rdy_rand = 1'b1;
    for (int n = 0; n < 250; n++) begin
      idle();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(16'($urandom), 4'($urandom), 1'($urandom),
           ROT_ON & 1'($urandom), 1'b0, 16'h0000, 1'b0);
    end
    drain();
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
